// File: rtl/game_round_ctrl.sv
// Maze-game round sequencer: idle, pre-start delay, timed play, then win or loss.
// Optional pause in PLAY via the GAME_ROUND_PAUSE_EN macro.
module game_round_ctrl #(
  parameter int GAME_SECONDS  = 45,
  parameter int DELAY_SECONDS = 3,
  parameter int LOW_THRESHOLD = 10
) (
  input  logic       clock,
  input  logic       resetkey,
  input  logic       tick,
  input  logic       startkey,
  input  logic       playkey,
  input  logic       win,
  output logic [7:0] countdown,
  output logic [7:0] delay,
  output logic [2:0] state,
  output logic       playing,
  output logic       game_over,
  output logic       won,
  output logic       time_low
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    PLAY   = 3'd2,
    WON    = 3'd3,
    LOST   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  localparam logic [7:0] GAME_RELOAD  = 8'(GAME_SECONDS);
  localparam logic [7:0] DELAY_RELOAD = 8'(DELAY_SECONDS);
  localparam logic [7:0] LOW_LEVEL    = 8'(LOW_THRESHOLD);

  // Two sync flops plus one history flop per key; press = synchronized falling edge.
  logic start_s1, start_s2, start_s3;
  logic play_s1, play_s2, play_s3;
  logic start_p, play_p;

  always_ff @(posedge clock or negedge resetkey) begin
    if (!resetkey) begin
      start_s1 <= 1'b1;
      start_s2 <= 1'b1;
      start_s3 <= 1'b1;
      play_s1  <= 1'b1;
      play_s2  <= 1'b1;
      play_s3  <= 1'b1;
    end else begin
      start_s1 <= startkey;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      play_s1  <= playkey;
      play_s2  <= play_s1;
      play_s3  <= play_s2;
    end
  end

  assign start_p = start_s3 & ~start_s2;
  assign play_p  = play_s3 & ~play_s2;

  state_t     state_q, state_d;
  logic [7:0] cd_q, cd_d;
  logic [7:0] dl_q, dl_d;

  always_ff @(posedge clock or negedge resetkey) begin
    if (!resetkey) begin
      state_q <= IDLE;
      cd_q    <= GAME_RELOAD;
      dl_q    <= DELAY_RELOAD;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      dl_q    <= dl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    dl_d    = dl_q;
    if (start_p) begin
      state_d = IDLE;
      cd_d    = GAME_RELOAD;
      dl_d    = DELAY_RELOAD;
    end else begin
      case (state_q)
        IDLE: begin
          cd_d = GAME_RELOAD;
          dl_d = DELAY_RELOAD;
          if (play_p) state_d = DELAY;
        end
        DELAY: begin
          if (tick) begin
            if (dl_q <= 8'd1) begin
              dl_d    = 8'd0;
              state_d = PLAY;
            end else begin
              dl_d = dl_q - 8'd1;
            end
          end
        end
        PLAY: begin
          // win outranks the final tick, freezing countdown at its current value
          if (win) begin
            state_d = WON;
          end
`ifdef GAME_ROUND_PAUSE_EN
          else if (play_p) begin
            state_d = PAUSED;
          end
`endif
          else if (tick) begin
            if (cd_q <= 8'd1) begin
              cd_d    = 8'd0;
              state_d = LOST;
            end else begin
              cd_d = cd_q - 8'd1;
            end
          end
        end
        WON, LOST: begin
          state_d = state_q;
        end
`ifdef GAME_ROUND_PAUSE_EN
        PAUSED: begin
          if (play_p) state_d = PLAY;
        end
`endif
        default: begin
          state_d = IDLE;
          cd_d    = GAME_RELOAD;
          dl_d    = DELAY_RELOAD;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign countdown = cd_q;
  assign delay     = dl_q;
  assign playing   = (state_q == PLAY);
  assign game_over = (state_q == WON) || (state_q == LOST);
  assign won       = (state_q == WON);
`ifdef GAME_ROUND_PAUSE_EN
  assign time_low  = ((state_q == PLAY) || (state_q == PAUSED)) && (cd_q <= LOW_LEVEL);
`else
  assign time_low  = (state_q == PLAY) && (cd_q <= LOW_LEVEL);
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: a vector table for round start, then
// hand-written sequences for expiry, win, restart and the pause feature.
module tb_game_round_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DELAY  = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_WON    = 3'd3;
  localparam logic [2:0] S_LOST   = 3'd4;
  localparam logic [2:0] S_PAUSED = 3'd5;

  logic       clock = 1'b0;
  logic       resetkey, tick, startkey, playkey, win;
  logic [7:0] countdown, delay;
  logic [2:0] state;
  logic       playing, game_over, won, time_low;

  int vectors = 0;
  int miscompares = 0;

  game_round_ctrl dut (
    .clock(clock), .resetkey(resetkey), .tick(tick), .startkey(startkey),
    .playkey(playkey), .win(win), .countdown(countdown), .delay(delay),
    .state(state), .playing(playing), .game_over(game_over), .won(won),
    .time_low(time_low)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       t, w, sk, pk;
    logic [2:0] st;
    logic [7:0] cd, dl;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [2:0] st, input logic [7:0] cd, input logic [7:0] dl);
    logic tl;
    tl = ((st == S_PLAY) || (st == S_PAUSED)) && (cd <= 8'd10);
    vectors++;
    if (state !== st) begin
      miscompares++;
      $display("FAIL %s state: got %0d want %0d", nm, state, st);
    end
    if (countdown !== cd) begin
      miscompares++;
      $display("FAIL %s countdown: got %0d want %0d", nm, countdown, cd);
    end
    if (delay !== dl) begin
      miscompares++;
      $display("FAIL %s delay: got %0d want %0d", nm, delay, dl);
    end
    if (playing !== (st == S_PLAY) || game_over !== (st == S_WON || st == S_LOST) ||
        won !== (st == S_WON) || time_low !== tl) begin
      miscompares++;
      $display("FAIL %s flags p/go/w/tl: got %b%b%b%b want %b%b%b%b", nm, playing, game_over,
               won, time_low, (st == S_PLAY), (st == S_WON || st == S_LOST), (st == S_WON), tl);
    end
  endtask

  // one clock with the given input levels held across the edge; outputs sampled 1 ns later
  task automatic cyc(input logic t, input logic w, input logic sk, input logic pk);
    @(negedge clock);
    tick = t; win = w; startkey = sk; playkey = pk;
    @(posedge clock);
    #1;
  endtask

  task automatic start_press(input logic [2:0] st, input logic [7:0] cd, input logic [7:0] dl);
    cyc(0, 0, 0, 1); chk("start_lat1", st, cd, dl);
    cyc(0, 0, 0, 1); chk("start_lat2", st, cd, dl);
    cyc(0, 0, 0, 1); chk("start_act", S_IDLE, 8'd45, 8'd3);
    cyc(0, 0, 1, 1); chk("start_rel", S_IDLE, 8'd45, 8'd3);
  endtask

  task automatic go_play();
    cyc(0, 0, 1, 0); chk("gp_lat1", S_IDLE, 8'd45, 8'd3);
    cyc(0, 0, 1, 0); chk("gp_lat2", S_IDLE, 8'd45, 8'd3);
    cyc(0, 0, 1, 0); chk("gp_delay", S_DELAY, 8'd45, 8'd3);
    cyc(1, 0, 1, 1); chk("gp_d2", S_DELAY, 8'd45, 8'd2);
    cyc(1, 0, 1, 1); chk("gp_d1", S_DELAY, 8'd45, 8'd1);
    cyc(1, 0, 1, 1); chk("gp_play", S_PLAY, 8'd45, 8'd0);
  endtask

  task automatic ticks_to(input logic [7:0] from, input logic [7:0] to);
    for (int i = int'(from) - 1; i >= int'(to); i--) begin
      cyc(1, 0, 1, 1);
      chk("play_tick", (i == 0) ? S_LOST : S_PLAY, 8'(i), 8'd0);
    end
  endtask

  initial begin
    //               t  w  sk pk  state    cd  dl
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, S_IDLE,  8'd45, 8'd3};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, S_IDLE,  8'd45, 8'd3};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, S_DELAY, 8'd45, 8'd3};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, S_DELAY, 8'd45, 8'd3};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, S_DELAY, 8'd45, 8'd3};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, S_DELAY, 8'd45, 8'd2};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, S_DELAY, 8'd45, 8'd2};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, S_DELAY, 8'd45, 8'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, S_PLAY,  8'd45, 8'd0};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b1, S_PLAY,  8'd44, 8'd0};

    resetkey = 1'b0; tick = 1'b0; win = 1'b0; startkey = 1'b1; playkey = 1'b1;
    #12;
    chk("reset", S_IDLE, 8'd45, 8'd3);
    @(negedge clock);
    resetkey = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].t, tbl[i].w, tbl[i].sk, tbl[i].pk);
      chk($sformatf("tbl%0d", i), tbl[i].st, tbl[i].cd, tbl[i].dl);
    end

    // expiry: through the low-time threshold down to LOST, then saturate
    ticks_to(8'd44, 8'd0);
    cyc(1, 1, 1, 1); chk("lost_sat", S_LOST, 8'd0, 8'd0);
    start_press(S_LOST, 8'd0, 8'd0);

    // win at 20 freezes the countdown; play press ignored in WON
    go_play();
    ticks_to(8'd45, 8'd20);
    cyc(0, 1, 1, 1); chk("win20", S_WON, 8'd20, 8'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 1); chk("won_frozen", S_WON, 8'd20, 8'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, (i == 3) ? 1'b1 : 1'b0); chk("won_play_ign", S_WON, 8'd20, 8'd0);
    end
    start_press(S_WON, 8'd20, 8'd0);

    // win and final tick together
    go_play();
    ticks_to(8'd45, 8'd1);
    cyc(1, 1, 1, 1); chk("win_last_tick", S_WON, 8'd1, 8'd0);
    start_press(S_WON, 8'd1, 8'd0);

    // start press landing with a tick in DELAY
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk("dly_enter", S_DELAY, 8'd45, 8'd3);
    cyc(1, 0, 1, 1); chk("dly_d2", S_DELAY, 8'd45, 8'd2);
    cyc(0, 0, 0, 1); chk("dly_st1", S_DELAY, 8'd45, 8'd2);
    cyc(0, 0, 0, 1); chk("dly_st2", S_DELAY, 8'd45, 8'd2);
    cyc(1, 0, 0, 1); chk("dly_start_tick", S_IDLE, 8'd45, 8'd3);
    cyc(0, 0, 1, 1); chk("dly_idle", S_IDLE, 8'd45, 8'd3);

    // play press in PLAY at 30
    go_play();
    ticks_to(8'd45, 8'd30);
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
`ifdef GAME_ROUND_PAUSE_EN
    chk("pause_enter", S_PAUSED, 8'd30, 8'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, (i == 1) ? 1'b1 : 1'b0, 1'b1, 1'b1); chk("paused_tick", S_PAUSED, 8'd30, 8'd0);
    end
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0); chk("resume", S_PLAY, 8'd30, 8'd0);
    cyc(1, 0, 1, 1); chk("resume_tick", S_PLAY, 8'd29, 8'd0);
`else
    chk("play_ign", S_PLAY, 8'd30, 8'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 1); chk("nopause_tick", S_PLAY, 8'(29 - i), 8'd0);
    end
`endif
    start_press(S_PLAY, countdown, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
